// File: rtl/dmc_preamble_deframer_if.sv
// Bit-stream in / payload-word out link between the DMC edge decoder and the
// preamble deframer.
interface dmc_preamble_deframer_if #(
  parameter int WORD_W = 8
);
  logic              bit_i;
  logic              bit_stb_i;
  logic [WORD_W-1:0] word_o;
  logic              word_vld_o;
  logic              preamble_double_check_o;
  logic              frame_done_o;
  logic              frame_err_o;
  logic              busy_o;
  logic [2:0]        state_o;

  modport master (
    output bit_i, bit_stb_i,
    input  word_o, word_vld_o, preamble_double_check_o, frame_done_o,
    input  frame_err_o, busy_o, state_o
  );

  modport slave (
    input  bit_i, bit_stb_i,
    output word_o, word_vld_o, preamble_double_check_o, frame_done_o,
    output frame_err_o, busy_o, state_o
  );
endinterface

// File: rtl/dmc_preamble_deframer.sv
// Hunts for a back-to-back 8-bit preamble in the decoded bit stream, then
// descrambles (x^7+x^6+1) and packs the payload into WORD_W-bit words.
module dmc_preamble_deframer #(
  parameter logic [7:0] PREAMBLE    = 8'b10101100,
  parameter int         WORD_W      = 8,
  parameter int         FRAME_WORDS = 4,
  parameter logic [6:0] LFSR_SEED   = 7'h7F,
  parameter int         TIMEOUT     = 64
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic                  enable,
  dmc_preamble_deframer_if.slave bus_if
);

  typedef enum logic [2:0] {
    S_HUNT    = 3'b001,
    S_CONFIRM = 3'b010,
    S_PAYLOAD = 3'b100
  } state_e;

  // bit_cnt also counts the 8 confirm strobes, so it never drops below 3 bits
  localparam int CNT_W = ($clog2(WORD_W) > 3) ? $clog2(WORD_W) : 3;
  localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [3:0]       WORD_LAST = 4'(FRAME_WORDS - 1);
  localparam logic [7:0]       TO_LAST   = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [6:0]        sr_q;
  logic [7:0]        sr_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic [WORD_W-2:0] shacc_q;
  logic [WORD_W-1:0] shacc_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [3:0]        word_cnt_q;
  logic [7:0]        tcnt_q;
  logic              d_bit;
  logic              pre_hit;

  logic [WORD_W-1:0] word_q;
  logic              word_vld_q, pdc_q, done_q, err_q, busy_q;

  // sr_q holds the seven most recent bits; the incoming bit completes the window
  assign sr_d    = {sr_q, bus_if.bit_i};
  assign pre_hit = (sr_d == PREAMBLE);
  assign d_bit   = bus_if.bit_i ^ lfsr_q[6];
  assign lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  assign shacc_d = {shacc_q, d_bit};

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q    <= S_HUNT;
      sr_q       <= '0;
      lfsr_q     <= LFSR_SEED;
      shacc_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tcnt_q     <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      pdc_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      word_vld_q <= 1'b0;
      pdc_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (!enable) begin
        state_q    <= S_HUNT;
        busy_q     <= 1'b0;
        sr_q       <= '0;
        shacc_q    <= '0;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        tcnt_q     <= '0;
      end else if (bus_if.bit_stb_i) begin
        sr_q   <= sr_d[6:0];
        tcnt_q <= '0;
        unique case (state_q)
          S_HUNT: begin
            if (pre_hit) begin
              state_q   <= S_CONFIRM;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
            end
          end
          S_CONFIRM: begin
            if (bit_cnt_q == CONF_LAST) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              if (pre_hit) begin
                pdc_q   <= 1'b1;
                lfsr_q  <= LFSR_SEED;
                state_q <= S_PAYLOAD;
              end else begin
                state_q <= S_HUNT;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          S_PAYLOAD: begin
            lfsr_q  <= lfsr_d;
            shacc_q <= shacc_d[WORD_W-2:0];
            if (bit_cnt_q == BIT_LAST) begin
              word_q     <= shacc_d;
              word_vld_q <= 1'b1;
              bit_cnt_q  <= '0;
              word_cnt_q <= word_cnt_q + 4'd1;
              if (word_cnt_q == WORD_LAST) begin
                done_q  <= 1'b1;
                state_q <= S_HUNT;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= S_HUNT;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (state_q != S_HUNT) begin
        // Strobe-less cycle while framing: abort once the gap reaches TIMEOUT
        if (tcnt_q == TO_LAST) begin
          err_q     <= 1'b1;
          state_q   <= S_HUNT;
          busy_q    <= 1'b0;
          tcnt_q    <= '0;
          bit_cnt_q <= '0;
        end else if (tcnt_q != 8'hFF) begin
          tcnt_q <= tcnt_q + 8'd1;
        end
      end
    end
  end

  assign bus_if.word_o                  = word_q;
  assign bus_if.word_vld_o              = word_vld_q;
  assign bus_if.preamble_double_check_o = pdc_q;
  assign bus_if.frame_done_o            = done_q;
  assign bus_if.frame_err_o             = err_q;
  assign bus_if.busy_o                  = busy_q;
  assign bus_if.state_o                 = state_q;

endmodule

// File: tb/tb_dmc_preamble_deframer.sv
// Scoreboard bench for dmc_preamble_deframer: a stream-level reference model
// queues expected states and pulses; a monitor pops and compares them.
module tb_dmc_preamble_deframer;
  localparam int         WORD_W      = 8;
  localparam int         FRAME_WORDS = 4;
  localparam logic [7:0] PREAMBLE    = 8'b10101100;
  localparam logic [6:0] LFSR_SEED   = 7'h7F;
  localparam int         TIMEOUT     = 64;
  localparam int         NBITS       = WORD_W * FRAME_WORDS;
  localparam int         M_HUNT = 0, M_CONF = 1, M_PAY = 2;

  logic clk_i  = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;

  dmc_preamble_deframer_if #(.WORD_W(WORD_W)) bus_if ();

  dmc_preamble_deframer #(
    .PREAMBLE(PREAMBLE), .WORD_W(WORD_W), .FRAME_WORDS(FRAME_WORDS),
    .LFSR_SEED(LFSR_SEED), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .reset(reset), .enable(enable), .bus_if(bus_if)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int unsigned       cyc;
    logic              vld;
    logic [WORD_W-1:0] word;
    logic              pdc;
    logic              done;
    logic              err;
  } ev_t;

  ev_t        ev_q[$];
  logic [2:0] st_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // reference model state: framing mode, last 8 bits seen, payload bits so far
  int          mode;
  logic [7:0]  hist;
  int          conf_n;
  logic        pay_q[$];
  int unsigned last_stb;
  logic        ks[NBITS];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    mode = M_HUNT;
    hist = '0;
    conf_n = 0;
    pay_q.delete();
  endtask

  task automatic m_step(input logic en, input logic stb, input logic b);
    ev_t  ev;
    logic fire;
    int   k;
    ev.cyc = cyc + 1; ev.vld = 0; ev.word = '0; ev.pdc = 0; ev.done = 0; ev.err = 0;
    fire = 0;
    if (!en) begin
      mode = M_HUNT;
      hist = '0;
    end else if (stb) begin
      hist = {hist[6:0], b};
      last_stb = cyc;
      if (mode == M_HUNT) begin
        if (hist == PREAMBLE) begin mode = M_CONF; conf_n = 0; end
      end else if (mode == M_CONF) begin
        conf_n++;
        if (conf_n == 8) begin
          if (hist == PREAMBLE) begin
            mode = M_PAY; pay_q.delete(); ev.pdc = 1; fire = 1;
          end else begin
            mode = M_HUNT;
          end
        end
      end else begin
        pay_q.push_back(b);
        if (pay_q.size() % WORD_W == 0) begin
          k = pay_q.size() / WORD_W - 1;
          for (int j = 0; j < WORD_W; j++)
            ev.word[WORD_W-1-j] = pay_q[k*WORD_W+j] ^ ks[k*WORD_W+j];
          ev.vld = 1; fire = 1;
          if (k == FRAME_WORDS - 1) begin ev.done = 1; mode = M_HUNT; end
        end
      end
    end else if (mode != M_HUNT && (cyc - last_stb) == TIMEOUT) begin
      ev.err = 1; fire = 1; mode = M_HUNT;
    end
    st_q.push_back(mode == M_HUNT ? 3'b001 : (mode == M_CONF ? 3'b010 : 3'b100));
    if (fire) ev_q.push_back(ev);
  endtask

  task automatic drive(input logic en, input logic stb, input logic b);
    @(negedge clk_i);
    enable = en;
    bus_if.bit_stb_i = stb;
    bus_if.bit_i = b;
    m_step(en, stb, b);
  endtask

  function automatic int gap_for(input int g);
    int r;
    if (g >= 0) return g;
    r = $urandom_range(0, 99);
    if (r < 2) return TIMEOUT - 1;
    if (r < 4) return TIMEOUT;
    return $urandom_range(0, 2);
  endfunction

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b, input int gap);
    drive(1'b1, 1'b1, b);
    idle(gap_for(gap));
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic guard();
    repeat (8) send_bit(1'b1, 0);
  endtask

  task automatic send_payload(input logic [NBITS-1:0] data, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) send_bit(data[NBITS-1-i] ^ ks[i], gap);
  endtask

  task automatic send_frame(input logic [NBITS-1:0] data, input int gap);
    send_byte(PREAMBLE, gap);
    send_byte(PREAMBLE, gap);
    send_payload(data, 0, NBITS - 1, gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state_o"}, bus_if.state_o, 3'b001);
    chk({tag, "_busy_o"}, bus_if.busy_o, 0);
    chk({tag, "_word_o"}, bus_if.word_o, 0);
    chk({tag, "_word_vld_o"}, bus_if.word_vld_o, 0);
    chk({tag, "_pdc_o"}, bus_if.preamble_double_check_o, 0);
    chk({tag, "_frame_done_o"}, bus_if.frame_done_o, 0);
    chk({tag, "_frame_err_o"}, bus_if.frame_err_o, 0);
  endtask

  // monitor: one state expectation per modelled cycle, one event per pulse
  initial begin
    ev_t        e;
    logic [2:0] s;
    forever begin
      @(posedge clk_i);
      #2;
      if (!reset) begin
        if (st_q.size() > 0) begin
          s = st_q.pop_front();
          chk("state_o", bus_if.state_o, s);
          chk("busy_o", bus_if.busy_o, (s != 3'b001));
        end
        if (bus_if.word_vld_o | bus_if.preamble_double_check_o |
            bus_if.frame_done_o | bus_if.frame_err_o) begin
          if (ev_q.size() == 0) begin
            chk("unexpected_pulse", {bus_if.word_vld_o, bus_if.preamble_double_check_o,
                                     bus_if.frame_done_o, bus_if.frame_err_o}, 0);
          end else begin
            e = ev_q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("word_vld_o", bus_if.word_vld_o, e.vld);
            if (e.vld) chk("word_o", bus_if.word_o, e.word);
            chk("pdc_o", bus_if.preamble_double_check_o, e.pdc);
            chk("frame_done_o", bus_if.frame_done_o, e.done);
            chk("frame_err_o", bus_if.frame_err_o, e.err);
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] l;
    bus_if.bit_i = 1'b0;
    bus_if.bit_stb_i = 1'b0;
    l = LFSR_SEED;
    for (int i = 0; i < NBITS; i++) begin
      ks[i] = l[6];
      l = {l[5:0], l[6] ^ l[5]};
    end
    m_reset();
    last_stb = 0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("por");
    reset = 1'b0;

    // clean double preamble, back-to-back strobes
    idle(2);
    guard();
    send_frame(32'h12345678, 0);
    idle(3);

    // single preamble followed by a near miss
    guard();
    send_byte(PREAMBLE, 0);
    send_byte(8'hAD, 0);
    idle(4);

    // timeout after the 2nd payload bit, then a clean frame
    guard();
    send_byte(PREAMBLE, 0);
    send_byte(PREAMBLE, 0);
    send_payload(32'hCAFE0123, 0, 1, 0);
    idle(TIMEOUT + 4);
    guard();
    send_frame(32'hA5C3_0FF0, 1);
    idle(3);

    // strobe lands exactly on the last allowed cycle
    guard();
    send_byte(PREAMBLE, 0);
    send_byte(PREAMBLE, 0);
    send_payload(32'h0BADBEEF, 0, 1, TIMEOUT - 1);
    send_payload(32'h0BADBEEF, 2, NBITS - 1, 0);
    idle(3);

    // enable dropped mid-payload, strobes during the drop are ignored
    guard();
    send_byte(PREAMBLE, 0);
    send_byte(PREAMBLE, 0);
    send_payload(32'h7E81_3C42, 0, 10, 0);
    repeat (3) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    idle(2);
    guard();
    send_frame(32'h6D2F_9B14, 0);
    idle(3);

    // asynchronous reset mid-payload
    guard();
    send_byte(PREAMBLE, 0);
    send_byte(PREAMBLE, 0);
    send_payload(32'h55AA_F00F, 0, 12, 0);
    @(negedge clk_i);
    bus_if.bit_stb_i = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    m_reset();
    repeat (2) @(negedge clk_i);
    reset = 1'b0;
    guard();
    send_frame(32'h3141_5926, 0);
    idle(3);

    // randomized frames with noise and occasional long gaps
    for (int f = 0; f < 10; f++) begin
      repeat ($urandom_range(0, 12)) send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) guard();
      send_frame($urandom(), -1);
    end

    idle(TIMEOUT + 5);
    repeat (3) @(negedge clk_i);
    chk("events_drained", ev_q.size(), 0);
    chk("states_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
